// File: rtl/hs4_pkg.sv
// Shared types and helpers for the four-phase bundled-data interface blocks.
package hs4_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        REQ_HI = 3'd2,
        REQ_LO = 3'd3,
        ERROR  = 3'd4
    } hs4_state_e;

    localparam int unsigned TIMEOUT_DEF = 1024;
    localparam int unsigned TMO_W_DEF   = $clog2(TIMEOUT_DEF + 1);

    // Width of a counter that must hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchroniser for a single asynchronous level; output is the last stage.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/hs4_bd_tx.sv
// Clocked initiator of a four-phase return-to-zero bundled-data handshake,
// fed by a valid/ready word interface, with phase timeout and transfer count.
module hs4_bd_tx
    import hs4_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic              err_o,
    input  logic              clear_i,
    output logic [CNT_W-1:0]  xfer_count_o,
    output hs4_state_e        state_o
);

    localparam int TMO_W = cnt_w(TIMEOUT);
    localparam int SET_W = cnt_w(SETUP_CYCLES);

    hs4_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SET_W-1:0]  setup_q, setup_d;
    logic              ack_s;
    logic              tmo_hit;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d_i (ack_i),
        .q_o (ack_s)
    );

    // Handshake: a word moves when in_valid_i && in_ready_o at a rising edge.
    // Ready is also held low during the done pulse so the next accept is never
    // in the completion cycle.
    assign in_ready_o = (state_q == IDLE) && !ack_s && !done_q;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        setup_d = setup_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    data_d  = in_data_i;
                    setup_d = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (setup_q == SET_W'(SETUP_CYCLES - 1)) begin
                    state_d = REQ_HI;
                    req_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    setup_d = setup_q + SET_W'(1);
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_d = REQ_LO;
                    req_d   = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d = ERROR;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (tmo_hit) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ERROR: begin
                req_d = 1'b0;
                // Leaving while ack is still high would let the next req collide.
                if (clear_i && !ack_s) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            setup_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            setup_q <= setup_d;
        end
    end

    assign req_o        = req_q;
    assign data_o       = data_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign xfer_count_o = cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_hs4_bd_tx.sv
// Directed and randomized checks of hs4_bd_tx against a transfer-level model.
module tb_hs4_bd_tx;
    import hs4_pkg::*;

    localparam int DATA_W  = 4;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready_o;
    logic              req_o;
    logic [DATA_W-1:0] data_o;
    logic              ack_i = 1'b0;
    logic              done_o;
    logic              err_o;
    logic              clear_i = 1'b0;
    logic [CNT_W-1:0]  xfer_count_o;
    hs4_state_e        state_o;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    hs4_bd_tx #(
        .DATA_W(DATA_W), .SYNC_STAGES(2), .SETUP_CYCLES(1),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready_o), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
        .done_o(done_o), .err_o(err_o), .clear_i(clear_i),
        .xfer_count_o(xfer_count_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
    endtask

    task automatic accept_word(input logic [DATA_W-1:0] word);
        in_data  = word;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready_o) begin
                tick();
                in_valid = 1'b0;
                exp_q.push_back(word);
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        check("accept_wait", 0, 1);
    endtask

    task automatic wait_req(input logic value, input string tag);
        for (int i = 0; i < 40; i++) begin
            if (req_o === value) return;
            tick();
        end
        check(tag, 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) return;
            tick();
        end
        check("done_wait", 0, 1);
    endtask

    // One complete transfer with an ack responder delayed d_hi / d_lo cycles.
    task automatic run_xfer(input logic [DATA_W-1:0] word, input int d_hi, input int d_lo);
        logic [DATA_W-1:0] exp_word;
        accept_word(word);
        check("setup_data", 32'(data_o), 32'(word));
        wait_req(1'b1, "req_rise_wait");
        check("req_hi_state", 32'(state_o), 32'(REQ_HI));
        repeat (d_hi) tick();
        ack_i = 1'b1;
        wait_req(1'b0, "req_fall_wait");
        check("hs_err_low", 32'(err_o), 0);
        repeat (d_lo) tick();
        ack_i = 1'b0;
        wait_done();
        exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
        exp_word = exp_q.pop_front();
        check("done_data", 32'(data_o), 32'(exp_word));
        check("done_count", 32'(xfer_count_o), 32'(exp_cnt));
        check("done_ready_low", 32'(in_ready_o), 0);
        check("done_req_low", 32'(req_o), 0);
        tick();
        check("done_one_cycle", 32'(done_o), 0);
    endtask

    initial begin
        int wrap_exp[5];
        wrap_exp = '{1, 2, 3, 0, 1};

        do_reset();
        check("rst_req", 32'(req_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_count", 32'(xfer_count_o), 0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_ready", 32'(in_ready_o), 1);

        // Basic transfer with exact edge timing (accept at edge k).
        repeat (3) tick();
        in_data  = 4'hB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("basic_setup_state", 32'(state_o), 32'(SETUP));
        check("basic_setup_req", 32'(req_o), 0);
        check("basic_setup_data", 32'(data_o), 32'hB);
        tick();
        check("basic_req_rise", 32'(req_o), 1);
        ack_i = 1'b1;
        tick();
        check("basic_req_k2", 32'(req_o), 1);
        tick();
        check("basic_req_k3", 32'(req_o), 1);
        tick();
        check("basic_req_fall", 32'(req_o), 0);
        check("basic_reqlo_state", 32'(state_o), 32'(REQ_LO));
        ack_i = 1'b0;
        tick();
        check("basic_done_k5", 32'(done_o), 0);
        tick();
        check("basic_done_k6", 32'(done_o), 0);
        tick();
        check("basic_done_k7", 32'(done_o), 1);
        check("basic_count", 32'(xfer_count_o), 1);
        check("basic_data_hold", 32'(data_o), 32'hB);
        check("basic_ready_in_done", 32'(in_ready_o), 0);
        tick();
        check("basic_done_k8", 32'(done_o), 0);
        check("basic_ready_after", 32'(in_ready_o), 1);
        check("basic_data_after", 32'(data_o), 32'hB);

        // Back-to-back with an immediately responding ack.
        do_reset();
        for (int i = 1; i <= 3; i++) run_xfer(DATA_W'(i), 0, 0);
        check("b2b_count", 32'(xfer_count_o), 3);

        // Ack raised while idle blocks ready but raises no error.
        ack_i = 1'b1;
        repeat (2) tick();
        check("viol_ready", 32'(in_ready_o), 0);
        check("viol_err", 32'(err_o), 0);
        ack_i = 1'b0;
        repeat (2) tick();
        check("viol_ready_back", 32'(in_ready_o), 1);

        // Timeout in REQ_HI.
        accept_word(4'h6);
        wait_req(1'b1, "tmo_req_wait");
        repeat (7) tick();
        check("tmo_err_early", 32'(err_o), 0);
        check("tmo_req_early", 32'(req_o), 1);
        tick();
        check("tmo_err", 32'(err_o), 1);
        check("tmo_req", 32'(req_o), 0);
        check("tmo_ready", 32'(in_ready_o), 0);
        check("tmo_state", 32'(state_o), 32'(ERROR));
        check("tmo_done", 32'(done_o), 0);
        check("tmo_count", 32'(xfer_count_o), 32'(exp_cnt));
        exp_q.delete();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("tmo_clear_err", 32'(err_o), 0);
        check("tmo_clear_ready", 32'(in_ready_o), 1);

        // Timeout in REQ_LO with ack stuck high; clear blocked until ack drops.
        accept_word(4'h9);
        wait_req(1'b1, "blk_req_wait");
        ack_i = 1'b1;
        wait_req(1'b0, "blk_fall_wait");
        repeat (7) tick();
        check("blk_err_early", 32'(err_o), 0);
        tick();
        check("blk_err", 32'(err_o), 1);
        check("blk_count", 32'(xfer_count_o), 32'(exp_cnt));
        exp_q.delete();
        clear_i = 1'b1;
        repeat (2) tick();
        check("blk_clear_ignored", 32'(err_o), 1);
        check("blk_state", 32'(state_o), 32'(ERROR));
        clear_i = 1'b0;
        ack_i   = 1'b0;
        repeat (3) tick();
        check("blk_err_hold", 32'(err_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("blk_clear_ok", 32'(err_o), 0);
        check("blk_idle", 32'(state_o), 32'(IDLE));

        // Reset in the middle of a handshake.
        run_xfer(4'h3, 1, 1);
        accept_word(4'hC);
        wait_req(1'b1, "mid_req_wait");
        tick();
        check("mid_in_reqhi", 32'(state_o), 32'(REQ_HI));
        rst = 1'b1;
        tick();
        check("mid_req", 32'(req_o), 0);
        check("mid_count", 32'(xfer_count_o), 0);
        check("mid_state", 32'(state_o), 32'(IDLE));
        check("mid_done", 32'(done_o), 0);
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        tick();
        check("mid_no_done", 32'(done_o), 0);

        // Counter wrap with a 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_xfer(DATA_W'($urandom_range(0, 15)), 0, 1);
            check("wrap_count", 32'(xfer_count_o), 32'(wrap_exp[i]));
        end

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_xfer(DATA_W'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        check("rand_err", 32'(err_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
